// File: rtl/weight_row_loader_if.sv
// Memory read port and PE weight row write port of the weight row loader.
// master: the loader; slave: the memory / PE array side.
interface weight_row_loader_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROW_WIDTH  = 40
);
    logic                  mem_rd_req;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic                  mem_rd_gnt;
    logic                  mem_rd_valid;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  row_wr_en;
    logic [2:0]            row_wr_idx;
    logic [ROW_WIDTH-1:0]  row_wr_data;

    modport master (
        output mem_rd_req, mem_rd_addr, row_wr_en, row_wr_idx, row_wr_data,
        input  mem_rd_gnt, mem_rd_valid, mem_rd_data
    );

    modport slave (
        input  mem_rd_req, mem_rd_addr, row_wr_en, row_wr_idx, row_wr_data,
        output mem_rd_gnt, mem_rd_valid, mem_rd_data
    );
endinterface

// File: rtl/weight_row_loader.sv
// Fetches one R x S int8 filter over a word-read handshake and writes it row by row into the
// PE weight row registers. Define WEIGHT_LOADER_PERF_EN to build the busy-cycle counter.
module weight_row_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned PE_ROWS    = 5,
    parameter int unsigned PE_COLS    = 5,
    parameter int unsigned W_BITS     = 8
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  start,
    input  logic [3:0]            param_R,
    input  logic [3:0]            param_S,
    input  logic [ADDR_WIDTH-1:0] weight_base_addr,
    weight_row_loader_if.master   bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           perf_cycles
);

    localparam int unsigned WordBytes = DATA_WIDTH / W_BITS;
    // Worst case residue is S-1 bytes plus one freshly read word.
    localparam int unsigned BufBytes  = PE_COLS - 1 + WordBytes;
    localparam int unsigned BufW      = BufBytes * W_BITS;
    localparam int unsigned RowW      = PE_COLS * W_BITS;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StUnpack, StDone} state_e;

    state_e                state_q, state_d;
    logic [3:0]            r_q, r_d;
    logic [3:0]            s_q, s_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [3:0]            word_cnt_q, word_cnt_d;
    logic [3:0]            byte_cnt_q, byte_cnt_d;
    logic [3:0]            row_cnt_q, row_cnt_d;
    logic [BufW-1:0]       buf_q, buf_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [2:0]            wr_idx_q, wr_idx_d;
    logic [RowW-1:0]       wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  start_ok;
    logic [BufW-1:0]       view_buf;
    logic [3:0]            view_cnt;
    logic [BufW-1:0]       shifted_buf;
    logic [RowW-1:0]       row_data;
    logic                  can_emit;

    assign start_ok = (param_R != 4'd0) && (param_R <= 4'(PE_ROWS)) &&
                      (param_S != 4'd0) && (param_S <= 4'(PE_COLS));

    // In WAIT the arriving word is merged so the first row leaves on the same edge.
    always_comb begin
        view_buf = buf_q;
        view_cnt = byte_cnt_q;
        if (state_q == StWait) begin
            view_buf = buf_q | (BufW'(bus.mem_rd_data) << {byte_cnt_q, 3'b000});
            view_cnt = byte_cnt_q + 4'(WordBytes);
        end
        shifted_buf = view_buf >> {s_q, 3'b000};
        row_data    = '0;
        for (int unsigned c = 0; c < PE_COLS; c++) begin
            if (4'(c) < s_q) begin
                row_data[c*W_BITS +: W_BITS] = view_buf[c*W_BITS +: W_BITS];
            end
        end
        can_emit = (view_cnt >= s_q) && (row_cnt_q < r_q);
    end

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        s_d        = s_q;
        base_d     = base_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        row_cnt_d  = row_cnt_q;
        buf_d      = buf_q;
        req_d      = req_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        wr_idx_d   = wr_idx_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (start_ok) begin
                        r_d        = param_R;
                        s_d        = param_S;
                        base_d     = weight_base_addr;
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
                        row_cnt_d  = '0;
                        buf_d      = '0;
                        req_d      = 1'b1;
                        addr_d     = weight_base_addr;
                        state_d    = StReq;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StReq: begin
                if (bus.mem_rd_gnt) begin
                    req_d      = 1'b0;
                    word_cnt_d = word_cnt_q + 4'd1;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (bus.mem_rd_valid) begin
                    buf_d      = view_buf;
                    byte_cnt_d = view_cnt;
                    state_d    = StUnpack;
                    if (can_emit) begin
                        wr_en_d    = 1'b1;
                        wr_idx_d   = row_cnt_q[2:0];
                        wr_data_d  = row_data;
                        buf_d      = shifted_buf;
                        byte_cnt_d = view_cnt - s_q;
                        row_cnt_d  = row_cnt_q + 4'd1;
                    end
                end
            end
            StUnpack: begin
                if (can_emit) begin
                    wr_en_d    = 1'b1;
                    wr_idx_d   = row_cnt_q[2:0];
                    wr_data_d  = row_data;
                    buf_d      = shifted_buf;
                    byte_cnt_d = view_cnt - s_q;
                    row_cnt_d  = row_cnt_q + 4'd1;
                end else if (row_cnt_q == r_q) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    req_d   = 1'b1;
                    addr_d  = base_q + ADDR_WIDTH'({word_cnt_q, 2'b00});
                    state_d = StReq;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q    <= StIdle;
            r_q        <= '0;
            s_q        <= '0;
            base_q     <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            row_cnt_q  <= '0;
            buf_q      <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            s_q        <= s_d;
            base_q     <= base_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            row_cnt_q  <= row_cnt_d;
            buf_q      <= buf_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.mem_rd_req  = req_q;
    assign bus.mem_rd_addr = addr_q;
    assign bus.row_wr_en   = wr_en_q;
    assign bus.row_wr_idx  = wr_idx_q;
    assign bus.row_wr_data = wr_data_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;

`ifdef WEIGHT_LOADER_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == StIdle) && start && start_ok) begin
            perf_d = '0;
        end else if (busy_q && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule
